servo_sched4: RTL and testbench
===============================

# servo_sched4

Four-channel servo frame scheduler running on the 1 MHz servo clock. It shares one 20 ms frame counter and pulse comparator across four servo outputs by giving each channel a 5 ms slot. Each channel's pulse width ramps toward a per-channel target by a fixed step once per frame. Targets are loaded through a valid/ready write port, so a host sequencer or the UI logic can retarget channels while the pulses are running.

## Interface
- FRAME_CLKS, 20000: frame length in mclk cycles (20 ms at 1 MHz).
- SLOT_CLKS, 5000: per-channel slot length; must satisfy 4*SLOT_CLKS == FRAME_CLKS.
- STEP, 10: width change per frame, in cycles.
- MIN_W, 0: lowest legal width.
- MAX_W, 2200: highest legal width; must be < SLOT_CLKS.
- RESET_W, 1100: width and target of every channel after reset.
- mclk  in  1  servo clock, 1 MHz.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  target write request.
- wr_ready  out  1  write accept; a write completes when wr_valid && wr_ready at a rising edge.
- wr_ch  in  2  channel index for the write.
- wr_target  in  12  requested width in cycles.
- freeze  in  1  hold all widths (see Configuration).
- mon_ch  in  2  monitor channel select.
- mon_width  out  12  current width of channel mon_ch, registered.
- pwm  out  4  servo pulse outputs, registered.
- busy  out  4  bit k high while width[k] != target[k].
- frame_tick  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- frame_cnt counts 0..FRAME_CLKS-1 and wraps to 0. slot = frame_cnt / SLOT_CLKS; slot_cnt = frame_cnt mod SLOT_CLKS. Counters are kept separately, with no divider.
- Update cycle: the cycle with frame_cnt == FRAME_CLKS-1. In it, each channel computes d = target - width:
  - |d| <= STEP: width <= target.
  - d > STEP: width <= width + STEP.
  - d < -STEP: width <= width - STEP.
  - Arithmetic is 13-bit signed, so there is no wrap.
- Write acceptance:
  - wr_ready = 0 during rst and in the update cycle; 1 otherwise.
  - On an accepted write, target[wr_ch] <= clamp(wr_target, MIN_W, MAX_W) on the next edge.
  - A later write to the same channel overwrites the earlier one. Ramping continues from the current width.
- Pulse generation: next-state pwm[k] = (slot == k) && (slot_cnt < width[k]).
  - Width 0 produces no pulse.
  - The width is constant within a frame because it changes only at the frame boundary.
- busy[k] is combinational from width/target registers. mon_width <= width[mon_ch] every cycle.
- Reset values:
  - frame_cnt = 0; width = target = RESET_W for all channels.
  - pwm = 0, frame_tick = 0, mon_width = 0, busy = 0, wr_ready = 0.
- Reset mid-frame: the frame is aborted. The next frame starts at frame_cnt = 0 on the first cycle after rst falls. Pending writes are discarded.

## Timing
- pwm[k] rises 1 cycle after frame_cnt == k*SLOT_CLKS. It stays high exactly width[k] cycles.
- frame_tick is high in the cycle where frame_cnt == 0, except the first frame after reset. The first tick comes FRAME_CLKS cycles after rst deasserts.
- Widths computed in the update cycle are visible at the frame_cnt == 0 edge, and pwm uses them from that frame on.
- Write-to-effect latency:
  - The target updates 1 cycle after acceptance.
  - The width first moves at the next update cycle.
  - Worst case, a full swing MIN_W to MAX_W at STEP=10 takes 220 frames.
- wr_ready drops for exactly one cycle per frame. A requester holding wr_valid is accepted on the following cycle.
- mon_width latency is 1 cycle.

## Configuration
- SERVO_SCHED_FREEZE_EN defined:
  - freeze sampled high in the update cycle suppresses all width updates for that frame.
  - Pulses continue at their current widths, and writes are still accepted.
- Undefined: the freeze port exists but is ignored, and widths always ramp.

## Test plan
- Reset release, no writes, 2 frames:
  - Each pwm[k] is high 1100 cycles, starting 1 cycle after frame_cnt = 5000k.
  - busy = 0.
  - frame_tick first appears 20000 cycles after reset.
- Write ch2 target 1500:
  - width[2] reads 1110, 1120, … on successive frames and reaches 1500 after 40 frames.
  - busy[2] falls in the same cycle the width reaches 1500.
- Write ch0 target 1105:
  - Because |d| = 5 <= STEP, width[0] = 1105 after one frame.
  - Write ch1 target 4000: target clamps to 2200.
  - Write ch3 target 0: the pulse disappears after 110 frames.
- Hold wr_valid asserted through the update cycle:
  - wr_ready = 0 for exactly that cycle.
  - The write is accepted at frame_cnt = 0.
  - The target takes effect only at the following update.
- With SERVO_SCHED_FREEZE_EN defined, freeze high for 3 update cycles during a ramp toward 1500:
  - width holds 3 frames.
  - The ramp resumes afterwards.
  - Without the macro, the same run ramps uninterrupted.
- Assert rst at frame_cnt = 7000 during ch1's pulse:
  - pwm = 0 next cycle.
  - widths and targets return to 1100.
  - The frame restarts at 0 after release.

Source files
------------

// File: rtl/servo_sched4.sv
// Four-channel servo frame scheduler: one shared frame/slot counter, per-channel ramped widths.
// Optional feature macro SERVO_SCHED_FREEZE_EN: when defined, freeze suppresses width updates.
module servo_sched4 #(
    parameter int unsigned FRAME_CLKS = 20000,
    parameter int unsigned SLOT_CLKS  = 5000,
    parameter int unsigned STEP       = 10,
    parameter int unsigned MIN_W      = 0,
    parameter int unsigned MAX_W      = 2200,
    parameter int unsigned RESET_W    = 1100
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_ch,
    input  logic [11:0] wr_target,
    input  logic        freeze,
    input  logic [1:0]  mon_ch,
    output logic [11:0] mon_width,
    output logic [3:0]  pwm,
    output logic [3:0]  busy,
    output logic        frame_tick
);

    localparam int unsigned SCW = ($clog2(SLOT_CLKS) > 12) ? $clog2(SLOT_CLKS) : 12;
    localparam logic [SCW-1:0]     SLOT_LAST = SCW'(SLOT_CLKS - 1);
    localparam logic signed [12:0] STEP_S    = 13'(STEP);
    localparam logic [11:0]        MIN_V     = 12'(MIN_W);
    localparam logic [11:0]        MAX_V     = 12'(MAX_W);
    localparam logic [11:0]        RESET_V   = 12'(RESET_W);

    if (4 * SLOT_CLKS != FRAME_CLKS) begin : g_bad_slot
        $error("servo_sched4: FRAME_CLKS must equal 4*SLOT_CLKS");
    end
    if (MAX_W >= SLOT_CLKS) begin : g_bad_max
        $error("servo_sched4: MAX_W must be below SLOT_CLKS");
    end

    // Frame position is held as (slot, slot_cnt) so no divider is needed.
    logic [1:0]         slot;
    logic [SCW-1:0]     slot_cnt;
    logic [11:0]        width  [4];
    logic [11:0]        target [4];
    logic [11:0]        next_w [4];
    logic signed [12:0] diff   [4];
    logic [11:0]        wr_clamped;
    logic               upd;
    logic               hold;

    assign upd      = (slot == 2'd3) && (slot_cnt == SLOT_LAST);
    assign wr_ready = !rst && !upd;

`ifdef SERVO_SCHED_FREEZE_EN
    assign hold = freeze;
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign hold = 1'b0;
`endif

    always_comb begin
        if (wr_target <= MIN_V)
            wr_clamped = MIN_V;
        else if (wr_target >= MAX_V)
            wr_clamped = MAX_V;
        else
            wr_clamped = wr_target;
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            diff[k]   = $signed({1'b0, target[k]}) - $signed({1'b0, width[k]});
            next_w[k] = width[k];
            if (diff[k] <= STEP_S && diff[k] >= -STEP_S)
                next_w[k] = target[k];
            else if (diff[k] > STEP_S)
                next_w[k] = width[k] + 12'(STEP);
            else
                next_w[k] = width[k] - 12'(STEP);
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned k = 0; k < 4; k++)
            busy[k] = (width[k] != target[k]);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            slot       <= '0;
            slot_cnt   <= '0;
            pwm        <= '0;
            frame_tick <= 1'b0;
            mon_width  <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                width[k]  <= RESET_V;
                target[k] <= RESET_V;
            end
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                slot     <= slot + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + SCW'(1);
            end

            // Tick lands on frame_cnt == 0 only after a wrap, never on the post-reset frame.
            frame_tick <= upd;

            for (int unsigned k = 0; k < 4; k++)
                pwm[k] <= (slot == 2'(k)) && (slot_cnt < SCW'(width[k]));

            mon_width <= width[mon_ch];

            if (upd && !hold) begin
                for (int unsigned k = 0; k < 4; k++)
                    width[k] <= next_w[k];
            end

            if (wr_valid && wr_ready)
                target[wr_ch] <= wr_clamped;
        end
    end

endmodule

// File: tb/tb_servo_sched4.sv
// Self-checking bench for servo_sched4 with a reduced frame size and an arithmetic reference model.
// Honours SERVO_SCHED_FREEZE_EN the same way the design does.
module tb_servo_sched4;

    localparam int FRAME = 400;
    localparam int SLOT  = 100;
    localparam int STP   = 4;
    localparam int MINW  = 0;
    localparam int MAXW  = 90;
    localparam int RSTW  = 50;

    logic        mclk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        freeze = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [1:0]  mon_ch = '0;
    logic [11:0] wr_target = '0;
    logic        wr_ready;
    logic        frame_tick;
    logic [11:0] mon_width;
    logic [3:0]  pwm;
    logic [3:0]  busy;

    int errors = 0;
    int checks = 0;

    // Reference model: frame position and per-channel width/target as plain integers.
    int          pos = 0;
    int          mw[4];
    int          mt[4];
    logic [3:0]  e_pwm = '0;
    logic        e_tick = 1'b0;
    logic [11:0] e_mon = '0;

    always #5 mclk = ~mclk;

    servo_sched4 #(
        .FRAME_CLKS(FRAME),
        .SLOT_CLKS (SLOT),
        .STEP      (STP),
        .MIN_W     (MINW),
        .MAX_W     (MAXW),
        .RESET_W   (RSTW)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_ch     (wr_ch),
        .wr_target (wr_target),
        .freeze    (freeze),
        .mon_ch    (mon_ch),
        .mon_width (mon_width),
        .pwm       (pwm),
        .busy      (busy),
        .frame_tick(frame_tick)
    );

    function automatic int clampw(int v);
        if (v < MINW) return MINW;
        if (v > MAXW) return MAXW;
        return v;
    endfunction

    function automatic int approach(int w, int t);
        int d;
        d = t - w;
        if (d <= STP && d >= -STP) return t;
        return (d > 0) ? w + STP : w - STP;
    endfunction

    function automatic logic [3:0] exp_busy();
        logic [3:0] b;
        b = '0;
        for (int k = 0; k < 4; k++) b[k] = (mw[k] != mt[k]);
        return b;
    endfunction

    function automatic logic exp_ready();
        return !rst && (pos != FRAME - 1);
    endfunction

    // Advance the model across one rising edge using the inputs present at it, then wait past the edge.
    task automatic step();
        logic frz;
`ifdef SERVO_SCHED_FREEZE_EN
        frz = freeze;
`else
        frz = 1'b0;
`endif
        if (rst) begin
            e_pwm  = '0;
            e_tick = 1'b0;
            e_mon  = '0;
            pos    = 0;
            for (int k = 0; k < 4; k++) begin
                mw[k] = RSTW;
                mt[k] = RSTW;
            end
        end else begin
            for (int k = 0; k < 4; k++)
                e_pwm[k] = (pos / SLOT == k) && (pos % SLOT < mw[k]);
            e_tick = (pos == FRAME - 1);
            e_mon  = 12'(mw[mon_ch]);
            if (pos == FRAME - 1 && !frz)
                for (int k = 0; k < 4; k++) mw[k] = approach(mw[k], mt[k]);
            if (wr_valid && pos != FRAME - 1)
                mt[wr_ch] = clampw(int'(wr_target));
            pos = (pos + 1) % FRAME;
        end
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        int highs[4];
        int rise[4];
        int first_tick;
        rst = 1'b1;
        repeat (3) step();
        checks++; if (pwm !== 4'b0) begin errors++; $display("FAIL reset_pwm got=%b want=0000", pwm); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
        checks++; if (mon_width !== 12'd0) begin errors++; $display("FAIL reset_mon got=%0d want=0", mon_width); end
        checks++; if (busy !== 4'b0) begin errors++; $display("FAIL reset_busy got=%b want=0000", busy); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", wr_ready); end
        rst = 1'b0;
        first_tick = -1;
        for (int k = 0; k < 4; k++) begin highs[k] = 0; rise[k] = -1; end
        for (int n = 1; n <= 2 * FRAME; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL idle_frames pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
            for (int k = 0; k < 4; k++)
                if (pwm[k] === 1'b1) begin highs[k]++; if (rise[k] < 0) rise[k] = n; end
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = n;
            mon_ch = 2'($urandom);
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (highs[k] !== 2 * RSTW) begin errors++; $display("FAIL pulse_len ch=%0d got=%0d want=%0d", k, highs[k], 2 * RSTW); end
            checks++; if (rise[k] !== k * SLOT + 1) begin errors++; $display("FAIL pulse_rise ch=%0d got=%0d want=%0d", k, rise[k], k * SLOT + 1); end
        end
        checks++; if (first_tick !== FRAME) begin errors++; $display("FAIL first_tick got=%0d want=%0d", first_tick, FRAME); end
    endtask

    task automatic test_ramp();
        int ticks;
        int done_at;
        ticks = 0;
        done_at = -1;
        wr_valid = 1'b1; wr_ch = 2'd2; wr_target = 12'(MAXW); mon_ch = 2'd2;
        step();
        wr_valid = 1'b0;
        for (int n = 0; n < 12 * FRAME && done_at < 0; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL ramp pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
            if (frame_tick === 1'b1) ticks++;
            if (busy[2] === 1'b0) done_at = ticks;
        end
        checks++;
        if (done_at !== (MAXW - RSTW) / STP) begin
            errors++; $display("FAIL ramp_frames got=%0d want=%0d", done_at, (MAXW - RSTW) / STP);
        end
    endtask

    task automatic test_boundary();
        int h0[16];
        int h1[16];
        int h3[16];
        int ticks;
        ticks = 0;
        for (int f = 0; f < 16; f++) begin h0[f] = 0; h1[f] = 0; h3[f] = 0; end
        wr_valid = 1'b1; wr_ch = 2'd0; wr_target = 12'(RSTW + 3);
        step();
        wr_ch = 2'd1; wr_target = 12'd4000;
        step();
        wr_ch = 2'd3; wr_target = 12'd0;
        step();
        wr_valid = 1'b0;
        for (int n = 0; n < 15 * FRAME; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL boundary pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
            if (frame_tick === 1'b1) ticks++;
            if (ticks < 16) begin
                if (pwm[0] === 1'b1) h0[ticks]++;
                if (pwm[1] === 1'b1) h1[ticks]++;
                if (pwm[3] === 1'b1) h3[ticks]++;
            end
            mon_ch = 2'($urandom);
        end
        checks++; if (h0[1] !== RSTW + 3) begin errors++; $display("FAIL small_step f1 got=%0d want=%0d", h0[1], RSTW + 3); end
        checks++; if (h0[2] !== RSTW + 3) begin errors++; $display("FAIL small_step f2 got=%0d want=%0d", h0[2], RSTW + 3); end
        checks++; if (h1[14] !== MAXW) begin errors++; $display("FAIL clamp_high got=%0d want=%0d", h1[14], MAXW); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL clamp_busy got=%b want=0", busy[1]); end
        checks++; if (h3[0] !== RSTW) begin errors++; $display("FAIL zero_f0 got=%0d want=%0d", h3[0], RSTW); end
        checks++; if (h3[12] !== RSTW - 12 * STP) begin errors++; $display("FAIL zero_f12 got=%0d want=%0d", h3[12], RSTW - 12 * STP); end
        checks++; if (h3[13] !== 0) begin errors++; $display("FAIL zero_f13 got=%0d want=0", h3[13]); end
    endtask

    task automatic test_back_to_back();
        mon_ch = 2'd1;
        for (int n = 0; n < FRAME && pos != FRAME - 1; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL b2b_lead pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
        end
        wr_valid = 1'b1; wr_ch = 2'd1; wr_target = 12'd30;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low got=%b want=0", wr_ready); end
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_high got=%b want=1", wr_ready); end
        checks++; if (busy[1] !== 1'b0) begin errors++; $display("FAIL b2b_not_taken got=%b want=0", busy[1]); end
        step();
        checks++; if (busy[1] !== 1'b1) begin errors++; $display("FAIL b2b_taken got=%b want=1", busy[1]); end
        wr_target = 12'd70;
        step();
        wr_valid = 1'b0;
        for (int n = 0; n < FRAME + 2; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL b2b_frame pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
        end
        checks++; if (mon_width !== 12'(MAXW - STP)) begin errors++; $display("FAIL b2b_width got=%0d want=%0d", mon_width, MAXW - STP); end
    endtask

    task automatic test_reset_mid();
        int first_tick;
        first_tick = -1;
        for (int n = 0; n < FRAME && pos != SLOT + 5; n++) step();
        checks++; if (pwm[1] !== 1'b1) begin errors++; $display("FAIL mid_pulse got=%b want=1", pwm[1]); end
        rst = 1'b1;
        step();
        checks++; if (pwm !== 4'b0) begin errors++; $display("FAIL mid_pwm got=%b want=0000", pwm); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got=%b want=0", wr_ready); end
        checks++; if (busy !== 4'b0) begin errors++; $display("FAIL mid_busy got=%b want=0000", busy); end
        step();
        rst = 1'b0;
        for (int n = 1; n <= FRAME + SLOT; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL mid_restart pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
            if (frame_tick === 1'b1 && first_tick < 0) first_tick = n;
            mon_ch = 2'($urandom);
        end
        checks++; if (first_tick !== FRAME) begin errors++; $display("FAIL mid_tick got=%0d want=%0d", first_tick, FRAME); end
    endtask

    task automatic test_freeze();
        int ticks;
        int want;
        ticks = 0;
        wr_valid = 1'b1; wr_ch = 2'd2; wr_target = 12'd10; mon_ch = 2'd2;
        step();
        wr_valid = 1'b0;
        for (int n = 0; n < 9 * FRAME && ticks < 8; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL freeze pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
            if (frame_tick === 1'b1) ticks++;
            freeze = (ticks >= 2 && ticks <= 4);
        end
        freeze = 1'b0;
        step();
        step();
`ifdef SERVO_SCHED_FREEZE_EN
        want = RSTW - 5 * STP;
`else
        want = RSTW - 8 * STP;
`endif
        checks++; if (mon_width !== 12'(want)) begin errors++; $display("FAIL freeze_width got=%0d want=%0d", mon_width, want); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30 * FRAME; n++) begin
            step();
            checks++;
            if ({pwm, frame_tick, busy, wr_ready, mon_width} !== {e_pwm, e_tick, exp_busy(), exp_ready(), e_mon}) begin
                errors++;
                $display("FAIL random pos=%0d got pwm=%b tick=%b busy=%b rdy=%b mon=%0d want pwm=%b tick=%b busy=%b rdy=%b mon=%0d",
                         pos, pwm, frame_tick, busy, wr_ready, mon_width, e_pwm, e_tick, exp_busy(), exp_ready(), e_mon);
            end
            wr_valid  = ($urandom_range(0, 15) == 0);
            wr_ch     = 2'($urandom);
            wr_target = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, MAXW));
            freeze    = ($urandom_range(0, 3) == 0);
            mon_ch    = 2'($urandom);
        end
        wr_valid = 1'b0;
        freeze   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        test_freeze();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
